// File: rtl/home_security_pkg.sv
// Shared definitions for the home-security front end: command encodings, keypad map,
// scanner state encodings and the key decode helpers.
package home_security_pkg;

  localparam logic [1:0] COM_NONE = 2'd0;
  localparam logic [1:0] COM_ARM  = 2'd1;
  localparam logic [1:0] COM_DIS  = 2'd2;

  // Key indices are row*4 + col, col 0 being col_n[0].
  localparam logic [3:0] KEY_A = 4'd3;
  localparam logic [3:0] KEY_B = 4'd7;

  // Key codes: 0-9 are digits, then A=10, B=11, C=12, D=13, *=14, #=15.
  localparam logic [3:0] KEY_MAP [0:15] = '{
    4'd1,  4'd2, 4'd3,  4'd10,
    4'd4,  4'd5, 4'd6,  4'd11,
    4'd7,  4'd8, 4'd9,  4'd12,
    4'd14, 4'd0, 4'd15, 4'd13
  };

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_EMIT     = 2'd2,
    S_RELEASE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] value;
    logic [1:0] command;
  } key_event_t;

  function automatic key_event_t decode_key(input logic [3:0] idx);
    key_event_t ev;
    logic [3:0] code;
    code = KEY_MAP[idx];
    ev   = '0;
    if (code <= 4'd9) begin
      ev.is_digit = 1'b1;
      ev.value    = code;
    end else if (idx == KEY_A) begin
      ev.command = COM_ARM;
    end else if (idx == KEY_B) begin
      ev.command = COM_DIS;
    end
    return ev;
  endfunction

  // True when exactly one column is pulled low.
  function automatic logic single_low(input logic [3:0] pat);
    logic [3:0] low;
    low = ~pat;
    return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_col(input logic [3:0] pat);
    logic [1:0] col;
    col = 2'd0;
    case (1'b0)
      pat[0]:  col = 2'd0;
      pat[1]:  col = 2'd1;
      pat[2]:  col = 2'd2;
      pat[3]:  col = 2'd3;
      default: col = 2'd0;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous keypad columns; idles at all-released.
module keypad_col_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] cs
);

  logic [3:0] meta;

  // NOTE: resetting to 4'b1111 makes the scanner see "no key" right after reset,
  // instead of a spurious press from an all-zero pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 4'b1111;
      cs   <= 4'b1111;
    end else begin
      meta <= col_n;
      cs   <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row rotation, press/release debounce and one event per press.
module keypad_scanner
  import home_security_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] digit,
  output logic       digit_enterd,
  output logic [1:0] command,
  output logic       busy
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);

  scan_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       row_idx;
  logic [1:0]       key_col;
  logic [3:0]       key_pat;
  logic [3:0]       cs;
  key_event_t       ev;

  keypad_col_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .col_n (col_n),
    .cs    (cs)
  );

  // The row index stays frozen outside SCAN, so it doubles as the latched row.
  assign ev = decode_key({row_idx, key_col});

  // NOTE: all state and outputs use non-blocking assignments so every branch reads
  // the values from before this edge; the strobes default low and pulse only on EMIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_SCAN;
      cnt          <= '0;
      row_idx      <= 2'd0;
      row_n        <= 4'b1110;
      key_col      <= 2'd0;
      key_pat      <= 4'b1111;
      digit        <= 4'd0;
      digit_enterd <= 1'b0;
      command      <= COM_NONE;
      busy         <= 1'b0;
    end else begin
      digit_enterd <= 1'b0;
      command      <= COM_NONE;
      case (state)
        S_SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (single_low(cs)) begin
              key_col <= low_col(cs);
              key_pat <= cs;
              busy    <= 1'b1;
              state   <= S_DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
              row_n   <= {row_n[2:0], row_n[3]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (cs != key_pat) begin
            cnt     <= '0;
            busy    <= 1'b0;
            state   <= S_SCAN;
            row_idx <= row_idx + 2'd1;
            row_n   <= {row_n[2:0], row_n[3]};
          end else if (cnt == DB_LAST) begin
            cnt   <= '0;
            state <= S_EMIT;
            if (ev.is_digit) begin
              digit_enterd <= 1'b1;
              digit        <= ev.value;
            end
            command <= ev.command;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EMIT: begin
          cnt   <= '0;
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          // Any low column restarts the release window, so bounce cannot re-trigger.
          if (cs != 4'b1111) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt     <= '0;
            busy    <= 1'b0;
            state   <= S_SCAN;
            row_idx <= row_idx + 2'd1;
            row_n   <= {row_n[2:0], row_n[3]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational membrane-keypad model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] digit;
  logic       digit_enterd;
  logic [1:0] command;
  logic       busy;
  logic [15:0] pressed;

  int total = 0;
  int bad   = 0;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .col_n        (col_n),
    .row_n        (row_n),
    .digit        (digit),
    .digit_enterd (digit_enterd),
    .command      (command),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  // Event log and busy-edge bookkeeping, sampled 1 time unit after each rising edge.
  int         cyc = 0;
  int         n_ev = 0;
  logic [3:0] ev_val [64];
  logic       ev_is_cmd [64];
  int         ev_cyc [64];
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  logic [3:0] rise_row = 4'h0;
  logic [3:0] fall_row = 4'h0;
  int         excl_bad = 0;
  int         frozen_bad = 0;
  logic       prev_busy = 1'b0;
  logic [3:0] prev_row = 4'b1110;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (digit_enterd || command != 2'd0) begin
      if (digit_enterd && command != 2'd0) excl_bad++;
      if (n_ev < 64) begin
        ev_is_cmd[n_ev] = (command != 2'd0);
        ev_val[n_ev]    = digit_enterd ? digit : {2'b00, command};
        ev_cyc[n_ev]    = cyc;
      end
      n_ev++;
    end
    if (busy && !prev_busy) begin
      rise_cyc = cyc;
      rise_row = row_n;
    end
    if (!busy && prev_busy) begin
      fall_cyc = cyc;
      fall_row = row_n;
    end
    if (busy && prev_busy && row_n != prev_row) frozen_bad++;
    prev_busy = busy;
    prev_row  = row_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic level, input string tag);
    int k;
    k = 0;
    while (busy !== level && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, k < 200, 1);
  endtask

  task automatic wait_event(input int base, input string tag);
    int k;
    k = 0;
    while (n_ev <= base && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, k < 200, 1);
  endtask

  task automatic press_key(input int idx, input string tag);
    int base;
    base = n_ev;
    pressed[idx] = 1'b1;
    wait_event(base, tag);
    tick(3);
    pressed = '0;
    wait_busy(1'b0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rel;
    int changes;
    int rot_bad;
    int busy_seen;
    logic [3:0] prev;

    pressed = '0;
    reset   = 1'b1;
    tick(2);
    check("rst_row_n",   row_n, 4'b1110);
    check("rst_digit",   digit, 0);
    check("rst_enterd",  digit_enterd, 0);
    check("rst_command", command, 0);
    check("rst_busy",    busy, 0);
    reset = 1'b0;

    // Key "4" held for 40 cycles: one strobe, row frozen until the release window ends.
    base = n_ev;
    pressed[4] = 1'b1;
    tick(40);
    rel = cyc;
    pressed = '0;
    wait_busy(1'b0, "t1_rel");
    check("t1_events",  n_ev - base, 1);
    check("t1_kind",    ev_is_cmd[base], 0);
    check("t1_digit",   ev_val[base], 4);
    check("t1_latency", ev_cyc[base] - rise_cyc, DEBOUNCE);
    check("t1_row",     rise_row, 4'b1101);
    check("t1_release", fall_cyc - rel, DEBOUNCE + 2);
    check("t1_row_next", fall_row, 4'b1011);
    tick(20);
    check("t1_no_second", n_ev - base, 1);

    // ARM then DISARM: two command pulses, digit output untouched.
    base = n_ev;
    press_key(3, "t2_a");
    press_key(7, "t2_b");
    check("t2_events",    n_ev - base, 2);
    check("t2_a_kind",    ev_is_cmd[base], 1);
    check("t2_a_cmd",     ev_val[base], 1);
    check("t2_b_kind",    ev_is_cmd[base+1], 1);
    check("t2_b_cmd",     ev_val[base+1], 2);
    check("t2_digit_hold", digit, 4);

    // Key "0" bounces during debounce: abort to row0, then one clean event.
    base = n_ev;
    pressed[13] = 1'b1;
    wait_busy(1'b1, "t3_det");
    tick(1);
    pressed[13] = 1'b0;
    tick(1);
    pressed[13] = 1'b1;
    wait_busy(1'b0, "t3_abort");
    check("t3_abort_row", row_n, 4'b1110);
    check("t3_abort_no_ev", n_ev - base, 0);
    wait_event(base, "t3_ev");
    tick(3);
    pressed = '0;
    wait_busy(1'b0, "t3_rel");
    check("t3_events", n_ev - base, 1);
    check("t3_kind",   ev_is_cmd[base], 0);
    check("t3_digit",  ev_val[base], 0);

    // PIN entry 4, 2, 0.
    base = n_ev;
    press_key(4, "t4_4");
    press_key(1, "t4_2");
    press_key(13, "t4_0");
    check("t4_events", n_ev - base, 3);
    check("t4_d0", ev_val[base], 4);
    check("t4_d1", ev_val[base+1], 2);
    check("t4_d2", ev_val[base+2], 0);

    // Two columns low on row1: ghost press ignored, rows keep rotating.
    base = n_ev;
    pressed[4] = 1'b1;
    pressed[5] = 1'b1;
    prev = row_n;
    changes = 0;
    rot_bad = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row_n != prev) begin
        changes++;
        if (row_n != {prev[2:0], prev[3]}) rot_bad++;
      end
      if (busy) busy_seen++;
      prev = row_n;
    end
    pressed = '0;
    check("t5_changes",   changes, 10);
    check("t5_rot_bad",   rot_bad, 0);
    check("t5_busy_seen", busy_seen, 0);
    check("t5_events",    n_ev - base, 0);

    // Reset while debouncing "7": immediate reset values, then one re-detected event.
    base = n_ev;
    pressed[8] = 1'b1;
    wait_busy(1'b1, "t6_det");
    tick(3);
    reset = 1'b1;
    #1;
    check("t6_rst_row",    row_n, 4'b1110);
    check("t6_rst_busy",   busy, 0);
    check("t6_rst_enterd", digit_enterd, 0);
    check("t6_rst_cmd",    command, 0);
    check("t6_rst_digit",  digit, 0);
    tick(2);
    reset = 1'b0;
    check("t6_no_partial", n_ev - base, 0);
    wait_event(base, "t6_ev");
    tick(3);
    pressed = '0;
    wait_busy(1'b0, "t6_rel");
    tick(20);
    check("t6_events", n_ev - base, 1);
    check("t6_kind",   ev_is_cmd[base], 0);
    check("t6_digit",  ev_val[base], 7);

    check("excl_strobes", excl_bad, 0);
    check("row_frozen",   frozen_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
